// File: rtl/cla_pipe_adder.sv
// Three-stage pipelined carry-lookahead adder/subtractor with a valid/ready handshake.
// Define CLA_PG_OUT_EN to expose the bit/group propagate-generate of the beat on sum.
module cla_pipe_adder #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 4,
    localparam int NBLK = (BLOCK < 1) ? 1 : WIDTH / BLOCK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
`ifdef CLA_PG_OUT_EN
    ,
    output logic [WIDTH-1:0] p_out,
    output logic [WIDTH-1:0] g_out,
    output logic [NBLK-1:0]  gp_out,
    output logic [NBLK-1:0]  gg_out
`endif
);

    generate
        if (BLOCK < 1 || (WIDTH % BLOCK) != 0) begin : g_bad_cfg
            $fatal(1, "cla_pipe_adder: WIDTH must be a positive multiple of BLOCK");
        end
    endgenerate

    // Carry out of bit 'top' of a group, as a flat MSB-first sum of products.
    function automatic logic carry_into(input logic [BLOCK-1:0] gv,
                                        input logic [BLOCK-1:0] pv,
                                        input logic             c_in,
                                        input int               top);
        logic term;
        logic prop;
        term = 1'b0;
        prop = 1'b1;
        for (int j = top; j >= 0; j--) begin
            term = term | (prop & gv[j]);
            prop = prop & pv[j];
        end
        return term | (prop & c_in);
    endfunction

    // Returns {G, P} for every group.
    function automatic logic [2*NBLK-1:0] group_pg(input logic [WIDTH-1:0] pv,
                                                   input logic [WIDTH-1:0] gv);
        logic [NBLK-1:0] gp;
        logic [NBLK-1:0] gg;
        gp = '0;
        gg = '0;
        for (int k = 0; k < NBLK; k++) begin
            gp[k] = &pv[k*BLOCK +: BLOCK];
            gg[k] = carry_into(gv[k*BLOCK +: BLOCK], pv[k*BLOCK +: BLOCK], 1'b0, BLOCK - 1);
        end
        return {gg, gp};
    endfunction

    // Each group carry is expanded all the way back to c0, so no carry ripples.
    function automatic logic [NBLK:0] group_carry(input logic [NBLK-1:0] gg,
                                                  input logic [NBLK-1:0] gp,
                                                  input logic            c0);
        logic [NBLK:0] c;
        logic          term;
        logic          prop;
        c    = '0;
        c[0] = c0;
        for (int k = 0; k < NBLK; k++) begin
            term = 1'b0;
            prop = 1'b1;
            for (int j = k; j >= 0; j--) begin
                term = term | (prop & gg[j]);
                prop = prop & gp[j];
            end
            c[k+1] = term | (prop & c0);
        end
        return c;
    endfunction

    function automatic logic [WIDTH-1:0] bit_carry(input logic [WIDTH-1:0] pv,
                                                   input logic [WIDTH-1:0] gv,
                                                   input logic [NBLK:0]    gc);
        logic [WIDTH-1:0] c;
        c = '0;
        for (int k = 0; k < NBLK; k++) begin
            for (int m = 0; m < BLOCK; m++) begin
                c[k*BLOCK + m] = carry_into(gv[k*BLOCK +: BLOCK], pv[k*BLOCK +: BLOCK],
                                            gc[k], m - 1);
            end
        end
        return c;
    endfunction

    logic             adv;
    logic [WIDTH-1:0] bb;

    logic             v1;
    logic [WIDTH-1:0] p1;
    logic [WIDTH-1:0] g1;
    logic             amsb1;
    logic             bbmsb1;
    logic             c0_1;

    logic             v2;
    logic [WIDTH-1:0] p2;
    logic [WIDTH-1:0] g2;
    logic [NBLK:0]    grp_c2;
    logic             amsb2;
    logic             bbmsb2;

    logic [2*NBLK-1:0] pg1;
    logic [NBLK:0]     grp_c1;
    logic [WIDTH-1:0]  carry2;
    logic [WIDTH-1:0]  sum_nxt;
    logic              ovf_nxt;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign bb       = sub ? ~b : b;

    assign pg1     = group_pg(p1, g1);
    assign grp_c1  = group_carry(pg1[2*NBLK-1:NBLK], pg1[NBLK-1:0], c0_1);
    assign carry2  = bit_carry(p2, g2, grp_c2);
    assign sum_nxt = p2 ^ carry2;
    assign ovf_nxt = (amsb2 == bbmsb2) && (sum_nxt[WIDTH-1] != amsb2);

`ifdef CLA_PG_OUT_EN
    logic [2*NBLK-1:0] pg2;
    assign pg2 = group_pg(p2, g2);
`endif

    // Every stage moves together on adv; data regs may load bubbles, only the v flags matter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1        <= 1'b0;
            p1        <= '0;
            g1        <= '0;
            amsb1     <= 1'b0;
            bbmsb1    <= 1'b0;
            c0_1      <= 1'b0;
            v2        <= 1'b0;
            p2        <= '0;
            g2        <= '0;
            grp_c2    <= '0;
            amsb2     <= 1'b0;
            bbmsb2    <= 1'b0;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
`ifdef CLA_PG_OUT_EN
            p_out     <= '0;
            g_out     <= '0;
            gp_out    <= '0;
            gg_out    <= '0;
`endif
        end else if (adv) begin
            v1        <= in_valid;
            p1        <= a ^ bb;
            g1        <= a & bb;
            amsb1     <= a[WIDTH-1];
            bbmsb1    <= bb[WIDTH-1];
            c0_1      <= sub ? 1'b1 : cin;

            v2        <= v1;
            p2        <= p1;
            g2        <= g1;
            grp_c2    <= grp_c1;
            amsb2     <= amsb1;
            bbmsb2    <= bbmsb1;

            out_valid <= v2;
            sum       <= sum_nxt;
            cout      <= grp_c2[NBLK];
            ovf       <= ovf_nxt;
`ifdef CLA_PG_OUT_EN
            p_out     <= p2;
            g_out     <= g2;
            gp_out    <= pg2[NBLK-1:0];
            gg_out    <= pg2[2*NBLK-1:NBLK];
`endif
        end
    end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed-vector and scoreboard bench for cla_pipe_adder (WIDTH=32, BLOCK=4).
module tb_cla_pipe_adder;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
`ifdef CLA_PG_OUT_EN
    logic [W-1:0] p_out;
    logic [W-1:0] g_out;
    logic [7:0]   gp_out;
    logic [7:0]   gg_out;
`endif

    cla_pipe_adder #(.WIDTH(W), .BLOCK(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
`ifdef CLA_PG_OUT_EN
        ,
        .p_out     (p_out),
        .g_out     (g_out),
        .gp_out    (gp_out),
        .gg_out    (gg_out)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } vec_t;

    vec_t vecs[13];

    // Reference from signed/unsigned integer arithmetic: {sum, cout, ovf}.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic ci, input logic s);
        longint sr;
        longint ur;
        logic   co;
        logic   ov;
        if (s) begin
            sr = longint'($signed(x)) - longint'($signed(y));
            co = (x >= y);
        end else begin
            sr = longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
            ur = longint'(x) + longint'(y) + longint'(ci);
            co = (ur > 64'sd4294967295);
        end
        ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        return {sr[W-1:0], co, ov};
    endfunction

    logic [W+1:0] exp_q[$];

    task automatic sb_observe();
        logic [W+1:0] e;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("rnd_spurious_out", 64'(out_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("rnd_result", 64'({sum, cout, ovf}), 64'(e));
            end
        end
        if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
    endtask

    initial begin
        int sent;
        int got;
        int stall;
        int last_cons;
        bit seen;

        vecs[0]  = '{32'h00000005, 32'h00000003, 1'b0, 1'b0, 32'h00000008, 1'b0, 1'b0};
        vecs[1]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vecs[2]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vecs[3]  = '{32'h00000003, 32'h00000005, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
        vecs[4]  = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
        vecs[5]  = '{32'h0000000F, 32'h00000000, 1'b1, 1'b0, 32'h00000010, 1'b0, 1'b0};
        vecs[6]  = '{32'h12345678, 32'h87654321, 1'b0, 1'b0, 32'h99999999, 1'b0, 1'b0};
        vecs[7]  = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1};
        vecs[8]  = '{32'h00000005, 32'h00000005, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0};
        vecs[9]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0};
        vecs[10] = '{32'h0FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h10000000, 1'b0, 1'b0};
        vecs[11] = '{32'h00000000, 32'h00000001, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[12] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b1};

        #2 rst_n = 1'b0;
        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_cout_ovf", 64'({cout, ovf}), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // in_ready follows adv only; empty pipe with consumer stalled still accepts
        out_ready = 1'b0;
        in_valid  = 1'b0;
        #1 check("in_ready_empty", 64'(in_ready), 64'd1);

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            a = vecs[i].a; b = vecs[i].b; cin = vecs[i].cin; sub = vecs[i].sub;
            in_valid = 1'b1; out_ready = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            check($sformatf("vec%0d_lat1", i), 64'(out_valid), 64'd0);
            @(negedge clk);
            check($sformatf("vec%0d_lat2", i), 64'(out_valid), 64'd0);
            @(negedge clk);
            check($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("vec%0d_sum", i), 64'(sum), 64'(vecs[i].s));
            check($sformatf("vec%0d_cout", i), 64'(cout), 64'(vecs[i].co));
            check($sformatf("vec%0d_ovf", i), 64'(ovf), 64'(vecs[i].ov));
        end

        // Backpressure: five beats i+i, consumer stalls 4 cycles at the first result
        repeat (2) @(negedge clk);
        sent = 0; got = 0; stall = 0; last_cons = -1; seen = 1'b0;
        for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
            out_ready = !(seen && stall < 4);
            if (!out_ready) stall++;
            in_valid = (sent < 5);
            a = W'(sent + 1); b = W'(sent + 1); cin = 1'b0; sub = 1'b0;
            #1;
            if (!out_ready) begin
                check("bp_in_ready_low", 64'(in_ready), 64'd0);
                check("bp_hold_valid", 64'(out_valid), 64'd1);
                check("bp_hold_sum", 64'(sum), 64'd2);
            end
            if (out_valid && out_ready) begin
                check("bp_order", 64'(sum), 64'(2 * (got + 1)));
                if (got > 0) check("bp_back_to_back", 64'(cyc - last_cons), 64'd1);
                last_cons = cyc;
                got++;
            end
            if (in_valid && in_ready) sent++;
        end
        check("bp_all_results", 64'(got), 64'd5);
        check("bp_stall_len", 64'(stall), 64'd4);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("bp_no_duplicate", 64'(out_valid), 64'd0);
        end

        // Reset with a full, stalled pipe
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            a = W'(100 + k); b = W'(1); in_valid = 1'b1; out_ready = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        #1 check("mid_full", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_sum", 64'(sum), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("mid_no_stale", 64'(out_valid), 64'd0);
        end
        @(negedge clk);
        a = 32'd9; b = 32'd1; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_valid", 64'(out_valid), 64'd1);
        check("post_rst_sum", 64'(sum), 64'd10);

`ifdef CLA_PG_OUT_EN
        @(negedge clk);
        a = 32'h0000000F; b = 32'h000000F0; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("pg_valid", 64'(out_valid), 64'd1);
        check("pg_p_out", 64'(p_out), 64'h000000FF);
        check("pg_g_out", 64'(g_out), 64'h0);
        check("pg_gp_out", 64'(gp_out), 64'h03);
        check("pg_gg_out", 64'(gg_out), 64'h00);
`endif

        // Random traffic with random backpressure against the integer model
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            a   = $urandom;
            b   = $urandom;
            cin = 1'($urandom_range(0, 1));
            sub = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: a = 32'hFFFFFFFF;
                1: b = 32'h80000000;
                2: begin a = W'($urandom_range(0, 15)); b = W'($urandom_range(0, 15)); end
                default: ;
            endcase
            #1 sb_observe();
        end
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
            @(negedge clk);
            in_valid = 1'b0; out_ready = 1'b1;
            #1 sb_observe();
        end
        check("rnd_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
